// File: rtl/sort_job_sched.sv
// sort_job_sched: queues sort jobs in a small FIFO and issues them one at a
// time on the bitonic sorter's sort_req/start_addr/data_count handshake,
// then reports a one-cycle completion pulse carrying the job tag and status.
module sort_job_sched #(
    parameter int ADDR     = 10,
    parameter int MAXCNT   = 1024,
    parameter int CNTW     = $clog2(MAXCNT) + 1,
    parameter int QDEPTH   = 4,
    parameter int ID_W     = 4,
    parameter int START_TO = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [ADDR-1:0]           job_start_addr,
    input  logic [CNTW-1:0]           job_count,
    input  logic [ID_W-1:0]           job_id,
    output logic                      sort_req,
    output logic [ADDR-1:0]           start_addr,
    output logic [CNTW-1:0]           data_count,
    input  logic                      sort_active,
    output logic                      done_valid,
    output logic [ID_W-1:0]           done_id,
    output logic [1:0]                done_status,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   q_level
);

    localparam int PW  = $clog2(QDEPTH);
    localparam int QLW = PW + 1;
    // End-address sum is one bit wider than the wider operand so it never wraps.
    localparam int SW  = ((ADDR > CNTW) ? ADDR : CNTW) + 1;
    localparam int TW  = (($clog2(START_TO) + 1) > 5) ? ($clog2(START_TO) + 1) : 5;

    localparam logic [CNTW-1:0] MAXCNT_C   = CNTW'(MAXCNT);
    localparam logic [SW-1:0]   ADDR_SPAN  = SW'(1) << ADDR;
    localparam logic [TW-1:0]   TO_LAST    = TW'(START_TO - 1);
    localparam logic [QLW-1:0]  QDEPTH_C   = QLW'(QDEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_TO    = 2'b01;
    localparam logic [1:0] ST_ZERO  = 2'b10;
    localparam logic [1:0] ST_RANGE = 2'b11;

    // Job FIFO storage (data only, never reset) and its control.
    logic [ADDR-1:0] mem_addr_q [QDEPTH];
    logic [ADDR-1:0] mem_addr_d [QDEPTH];
    logic [CNTW-1:0] mem_cnt_q  [QDEPTH];
    logic [CNTW-1:0] mem_cnt_d  [QDEPTH];
    logic [ID_W-1:0] mem_id_q   [QDEPTH];
    logic [ID_W-1:0] mem_id_d   [QDEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QLW-1:0]  q_level_q, q_level_d;

    // Scheduler state.
    logic [1:0]      state_q, state_d;
    logic            sort_req_q, sort_req_d;
    logic [ADDR-1:0] start_addr_q, start_addr_d;
    logic [CNTW-1:0] data_count_q, data_count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic [1:0]      status_q, status_d;
    logic            done_valid_q, done_valid_d;
    logic [ID_W-1:0] done_id_q, done_id_d;
    logic [1:0]      done_status_q, done_status_d;

    logic            push;
    logic            pop;
    logic            empty;
    logic [ADDR-1:0] head_addr;
    logic [CNTW-1:0] head_cnt;
    logic [ID_W-1:0] head_id;
    logic [SW-1:0]   end_sum;

    assign empty     = (q_level_q == '0);
    assign job_ready = (q_level_q != QDEPTH_C);
    assign push      = job_valid && job_ready;
    assign head_addr = mem_addr_q[rd_ptr_q];
    assign head_cnt  = mem_cnt_q[rd_ptr_q];
    assign head_id   = mem_id_q[rd_ptr_q];
    assign end_sum   = SW'(head_addr) + SW'(head_cnt);

    // Scheduler FSM: pop/validate in IDLE, hold the request in ISSUE, wait out the sort in RUN.
    always_comb begin
        state_d       = state_q;
        sort_req_d    = 1'b0;
        start_addr_d  = start_addr_q;
        data_count_d  = data_count_q;
        timer_d       = timer_q;
        cur_id_d      = cur_id_q;
        status_d      = status_q;
        done_valid_d  = 1'b0;
        done_id_d     = done_id_q;
        done_status_d = done_status_q;
        pop           = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A sorter still busy (e.g. after our own reset) blocks the next pop.
                if (!empty && !sort_active) begin
                    pop      = 1'b1;
                    cur_id_d = head_id;
                    if (head_cnt == '0) begin
                        state_d  = S_DONE;
                        status_d = ST_ZERO;
                    end else if ((head_cnt > MAXCNT_C) || (end_sum > ADDR_SPAN)) begin
                        state_d  = S_DONE;
                        status_d = ST_RANGE;
                    end else begin
                        state_d      = S_ISSUE;
                        start_addr_d = head_addr;
                        data_count_d = head_cnt;
                        timer_d      = '0;
                    end
                end
            end
            S_ISSUE: begin
                // The first ISSUE cycle only raises sort_req; acknowledgement counts once it is out.
                if (sort_req_q && sort_active) begin
                    state_d = S_RUN;
                end else if (sort_req_q && (timer_q == TO_LAST)) begin
                    state_d  = S_DONE;
                    status_d = ST_TO;
                end else begin
                    sort_req_d = 1'b1;
                    if (sort_req_q) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!sort_active) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end
            end
            default: begin
                done_valid_d  = 1'b1;
                done_id_d     = cur_id_q;
                done_status_d = status_q;
                state_d       = S_IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy update and entry write.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_cnt_d  = mem_cnt_q;
        mem_id_d   = mem_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        q_level_d  = q_level_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = job_start_addr;
            mem_cnt_d[wr_ptr_q]  = job_count;
            mem_id_d[wr_ptr_q]   = job_id;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   q_level_d = q_level_q + 1'b1;
            2'b01:   q_level_d = q_level_q - 1'b1;
            default: q_level_d = q_level_q;
        endcase
    end

    // Control and output registers with synchronous reset; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            q_level_q     <= '0;
            state_q       <= S_IDLE;
            sort_req_q    <= 1'b0;
            start_addr_q  <= '0;
            data_count_q  <= '0;
            timer_q       <= '0;
            cur_id_q      <= '0;
            status_q      <= ST_OK;
            done_valid_q  <= 1'b0;
            done_id_q     <= '0;
            done_status_q <= ST_OK;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            q_level_q     <= q_level_d;
            state_q       <= state_d;
            sort_req_q    <= sort_req_d;
            start_addr_q  <= start_addr_d;
            data_count_q  <= data_count_d;
            timer_q       <= timer_d;
            cur_id_q      <= cur_id_d;
            status_q      <= status_d;
            done_valid_q  <= done_valid_d;
            done_id_q     <= done_id_d;
            done_status_q <= done_status_d;
        end
    end

    // FIFO entry storage carries no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_addr_q <= mem_addr_d;
        mem_cnt_q  <= mem_cnt_d;
        mem_id_q   <= mem_id_d;
    end

    assign sort_req    = sort_req_q;
    assign start_addr  = start_addr_q;
    assign data_count  = data_count_q;
    assign done_valid  = done_valid_q;
    assign done_id     = done_id_q;
    assign done_status = done_status_q;
    assign q_level     = q_level_q;
    assign busy        = (state_q != S_IDLE) || !empty || done_valid_q;

endmodule

// File: tb/tb_sort_job_sched.sv
// Directed testbench for sort_job_sched: queueing, issue handshake, rejects,
// start timeout and reset mid-job, with hand-computed expectations.
module tb_sort_job_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [9:0]  job_start_addr;
    logic [10:0] job_count;
    logic [3:0]  job_id;
    logic        sort_req;
    logic [9:0]  start_addr;
    logic [10:0] data_count;
    logic        sort_active;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [1:0]  done_status;
    logic        busy;
    logic [2:0]  q_level;

    int n_vec = 0;
    int n_err = 0;

    sort_job_sched dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_start_addr (job_start_addr),
        .job_count      (job_count),
        .job_id         (job_id),
        .sort_req       (sort_req),
        .start_addr     (start_addr),
        .data_count     (data_count),
        .sort_active    (sort_active),
        .done_valid     (done_valid),
        .done_id        (done_id),
        .done_status    (done_status),
        .busy           (busy),
        .q_level        (q_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sorter model for one issued job: acknowledge, run a few cycles, finish.
    task automatic serve(input logic [3:0] id, input logic [9:0] addr, input logic [10:0] cnt);
        int w;
        w = 0;
        while (!sort_req && w < 20) begin
            step();
            w++;
        end
        check("issue_seen", sort_req, 1);
        check("issue_addr", start_addr, addr);
        check("issue_cnt", data_count, cnt);
        sort_active = 1'b1;
        step();
        check("req_drop", sort_req, 0);
        repeat (3) step();
        sort_active = 1'b0;
        w = 0;
        while (!done_valid && w < 20) begin
            step();
            w++;
        end
        check("done_seen", done_valid, 1);
        check("done_id", done_id, id);
        check("done_ok", done_status, 0);
        check("done_cycle_req", sort_req, 0);
        step();
        check("done_pulse", done_valid, 0);
        check("idle_gap_req", sort_req, 0);
    endtask

    // Rejected job: completion two edges after acceptance, never a request.
    task automatic reject(input logic [3:0] id, input logic [9:0] addr, input logic [10:0] cnt,
                          input logic [1:0] st);
        job_valid      = 1'b1;
        job_start_addr = addr;
        job_count      = cnt;
        job_id         = id;
        step();
        job_valid = 1'b0;
        step();
        check("rej_early_done", done_valid, 0);
        check("rej_req1", sort_req, 0);
        step();
        check("rej_done", done_valid, 1);
        check("rej_id", done_id, id);
        check("rej_status", done_status, st);
        check("rej_req2", sort_req, 0);
        step();
        check("rej_pulse", done_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;
        int hi;

        rst            = 1'b1;
        job_valid      = 1'b0;
        job_start_addr = '0;
        job_count      = '0;
        job_id         = '0;
        sort_active    = 1'b0;
        step();
        step();
        check("rst_ready", job_ready, 1);
        check("rst_req", sort_req, 0);
        check("rst_addr", start_addr, 0);
        check("rst_cnt", data_count, 0);
        check("rst_done", done_valid, 0);
        check("rst_id", done_id, 0);
        check("rst_status", done_status, 0);
        check("rst_busy", busy, 0);
        check("rst_level", q_level, 0);
        rst = 1'b0;

        // Single job, sorter acknowledges after 3 request cycles.
        job_valid      = 1'b1;
        job_start_addr = 10'd0;
        job_count      = 11'd100;
        job_id         = 4'd3;
        step();
        job_valid = 1'b0;
        check("t1_level_acc", q_level, 1);
        step();
        check("t1_req_pop", sort_req, 0);
        check("t1_level_pop", q_level, 0);
        check("t1_busy", busy, 1);
        step();
        check("t1_req_c1", sort_req, 1);
        check("t1_addr", start_addr, 0);
        check("t1_cnt", data_count, 100);
        step();
        check("t1_req_c2", sort_req, 1);
        step();
        check("t1_req_c3", sort_req, 1);
        sort_active = 1'b1;
        step();
        check("t1_req_drop", sort_req, 0);
        spur = 0;
        repeat (49) begin
            step();
            if (sort_req || done_valid) spur++;
        end
        check("t1_run_quiet", spur, 0);
        sort_active = 1'b0;
        step();
        check("t1_done_early", done_valid, 0);
        step();
        check("t1_done", done_valid, 1);
        check("t1_done_id", done_id, 3);
        check("t1_done_st", done_status, 0);
        step();
        check("t1_pulse", done_valid, 0);
        check("t1_busy_after", busy, 0);
        check("t1_id_hold", done_id, 3);

        // Four jobs while the sorter reports busy: nothing pops, FIFO fills.
        sort_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            job_valid      = 1'b1;
            job_start_addr = 10'(10 * i);
            job_count      = 11'(8 + i);
            job_id         = 4'(i);
            step();
            if (i == 2) begin
                check("t2_level3", q_level, 3);
                check("t2_ready3", job_ready, 1);
            end
        end
        check("t2_full_ready", job_ready, 0);
        check("t2_full_level", q_level, 4);
        job_id = 4'd9;
        step();
        job_valid = 1'b0;
        check("t2_full_ignore", q_level, 4);
        check("t2_idle_ignore", sort_req, 0);
        sort_active = 1'b0;
        step();
        check("t2_first_pop", q_level, 3);
        check("t2_ready_pop", job_ready, 1);
        serve(4'd0, 10'd0, 11'd8);
        serve(4'd1, 10'd10, 11'd9);
        serve(4'd2, 10'd20, 11'd10);
        serve(4'd3, 10'd30, 11'd11);

        // Rejects: zero count, end past SRAM, count above maximum.
        reject(4'd5, 10'd0, 11'd0, 2'b10);
        reject(4'd6, 10'd1000, 11'd30, 2'b11);
        reject(4'd4, 10'd0, 11'd1025, 2'b11);
        check("rej_hold_addr", start_addr, 30);
        check("rej_hold_cnt", data_count, 11);

        // Job ending exactly at the top of SRAM is legal.
        job_valid      = 1'b1;
        job_start_addr = 10'd994;
        job_count      = 11'd30;
        job_id         = 4'd7;
        step();
        job_valid = 1'b0;
        serve(4'd7, 10'd994, 11'd30);

        // Start timeout with a second job queued behind it.
        job_valid      = 1'b1;
        job_start_addr = 10'd5;
        job_count      = 11'd4;
        job_id         = 4'd8;
        step();
        job_start_addr = 10'd40;
        job_count      = 11'd12;
        job_id         = 4'd9;
        step();
        job_valid = 1'b0;
        check("t5_push_pop_level", q_level, 1);
        check("t5_req_pop", sort_req, 0);
        step();
        hi = 0;
        while (sort_req && hi < 40) begin
            hi++;
            step();
        end
        check("t5_req_len", hi, 16);
        check("t5_done_early", done_valid, 0);
        step();
        check("t5_done", done_valid, 1);
        check("t5_done_id", done_id, 8);
        check("t5_done_st", done_status, 1);
        serve(4'd9, 10'd40, 11'd12);

        // Reset during RUN with two jobs queued.
        job_valid      = 1'b1;
        job_start_addr = 10'd100;
        job_count      = 11'd16;
        job_id         = 4'd10;
        step();
        job_id = 4'd11;
        step();
        job_id = 4'd12;
        step();
        job_valid = 1'b0;
        check("t6_req", sort_req, 1);
        check("t6_level", q_level, 2);
        sort_active = 1'b1;
        step();
        check("t6_run_req", sort_req, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_level", q_level, 0);
        check("t6_rst_req", sort_req, 0);
        check("t6_rst_ready", job_ready, 1);
        check("t6_rst_busy", busy, 0);
        job_valid      = 1'b1;
        job_start_addr = 10'd200;
        job_count      = 11'd20;
        job_id         = 4'd13;
        step();
        job_valid = 1'b0;
        check("t6_new_level", q_level, 1);
        spur = 0;
        repeat (5) begin
            step();
            if (sort_req || q_level != 3'd1) spur++;
        end
        check("t6_wait_sorter", spur, 0);
        sort_active = 1'b0;
        step();
        check("t6_pop", q_level, 0);
        serve(4'd13, 10'd200, 11'd20);
        check("end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
